fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `fifo` write interface between NUM_REQ requesters. It sits directly in front of a `fifo` instance's `wr_en`/`wr_data`/`wr_full` port. It grants the port to one requester at a time for a burst of up to BURST_LEN beats, then rotates priority. Beats pass combinationally in the granted state, so `wr_full` back-pressure is honoured in the same cycle and the FIFO is never overrun.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; legal range ≥ 2.
- BYTE_WIDTH, 1, data width in bytes; matches the downstream `fifo` BYTE_WIDTH.
- BURST_LEN, 16, maximum accepted beats per grant; legal range ≥ 1.

Ports (clock and reset first):
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- req_wr_en  in  NUM_REQ  per-requester write request/valid; bit i belongs to requester i.
- req_wr_data  in  NUM_REQ*BYTE_WIDTH*8  packed data; requester i occupies slice [i*BYTE_WIDTH*8 +: BYTE_WIDTH*8].
- req_wr_ack  out  NUM_REQ  beat accepted from requester i this cycle.
- req_grant  out  NUM_REQ  one-hot current owner; all zeros when idle.
- fifo_wr_en  out  1  to `fifo` wr_en.
- fifo_wr_data  out  BYTE_WIDTH*8  to `fifo` wr_data.
- fifo_wr_full  in  1  from `fifo` wr_full.
- busy  out  1  high while in GRANT.

## Operation
Registered state:
- FSM state, IDLE or GRANT.
- owner index, width clog2(NUM_REQ).
- rr pointer, same width as owner.
- beat counter, width clog2(BURST_LEN)+1.

IDLE:
- req_grant = 0. fifo_wr_en = 0. fifo_wr_data = 0. req_wr_ack = 0.
- If any req_wr_en bit is set, search from index pointer+1 upward, with modulo NUM_REQ wrap. Select the first set bit.
- On selection: owner ← selected, pointer ← selected, counter ← 0, state ← GRANT.

GRANT:
- accept = req_wr_en[owner] & ~fifo_wr_full.
- fifo_wr_en = accept. fifo_wr_data = slice[owner]. req_wr_ack = accept one-hot at owner.
- req_grant is one-hot at owner. Data from non-owners is ignored and never acked.
- On accept: counter ← counter+1.
- Release to IDLE when either condition holds:
  - accept and counter == BURST_LEN-1 (last beat of the burst), or
  - req_wr_en[owner] == 0 (owner withdrew), regardless of fifo_wr_full.
- While req_wr_en[owner]=1 and fifo_wr_full=1: stall. Grant, counter and state are held, and no beat is acked.

Boundary conditions:
- Pointer wrap: after owner NUM_REQ-1, the search starts at requester 0.
- Single active requester: it is re-granted after the one-cycle IDLE gap.
- Requests arriving during GRANT do not pre-empt the owner. They are considered at the next IDLE.
- Reset mid-burst: the in-flight burst is dropped with no further acks. The FIFO keeps only the beats already written.

## Timing
- Reset values: state IDLE, pointer NUM_REQ-1 (so the first search starts at 0), owner 0, counter 0.
- Output values under reset: all outputs 0, including req_grant, req_wr_ack, fifo_wr_en, fifo_wr_data and busy.
- Arbitration latency: a request seen in IDLE at edge N gives grant and busy high from edge N+1. The first beat can be accepted in cycle N+1.
- Beat path in GRANT is combinational, with zero-cycle latency from req_wr_en/fifo_wr_full to fifo_wr_en/req_wr_ack.
- Handshake: a requester holds req_wr_data stable until it sees req_wr_ack for that beat.
- Throughput:
  - One beat per cycle within a burst.
  - Exactly one IDLE cycle between consecutive grants.
  - Sustained rate with all requesters active and no back-pressure is BURST_LEN/(BURST_LEN+1).

## Test plan
- Reset: hold rst 3 cycles with all req_wr_en=1 -> all outputs 0 throughout. After release, the first grant goes to requester 0 one cycle later.
- Round-robin, NUM_REQ=4, BURST_LEN=4, all requesting continuously, fifo_wr_full=0 -> grant order 0,1,2,3,0. Each burst is exactly 4 consecutive fifo_wr_en beats followed by 1 idle cycle. FIFO receives 20 beats in 25 cycles with data taken from the correct slices.
- Back-pressure: fifo_wr_full=1 for 3 cycles after beat 2 of requester 1 -> fifo_wr_en and req_wr_ack are 0 during the stall. Grant stays at 1 and the counter holds. The burst resumes and ends after 4 total beats.
- Early release: requester 2 drops req_wr_en after 2 beats while requesters 3 and 0 are requesting -> IDLE next cycle, then grant to 3.
- Single requester 3, continuous -> repeating pattern of 4 beats then 1 idle cycle, with grant always 3 and the pointer wrapping correctly.
- Reset mid-burst after beat 1 of requester 0 -> outputs 0 on the next edge. After release, a fresh search starts at requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares one fifo write port between NUM_REQ
// requesters. The owner keeps the port for a burst of up to BURST_LEN
// accepted beats. After that, priority rotates to the next requester.
// While a requester is granted, beats pass combinationally. This lets
// fifo_wr_full stall a beat in the same cycle it is offered.
//
// Ports
//   clk           single clock
//   rst           synchronous, active-high reset
//   req_wr_en     per-requester write request / valid
//   req_wr_data   packed data, requester i at [i*BYTE_WIDTH*8 +: BYTE_WIDTH*8]
//   req_wr_ack    beat accepted from requester i this cycle
//   req_grant     one-hot current owner, zero when idle
//   fifo_wr_en    to fifo wr_en
//   fifo_wr_data  to fifo wr_data
//   fifo_wr_full  from fifo wr_full
//   busy          high while a grant is held
//
// state   | meaning
// S_IDLE  | no owner; search for the next requester after r_ptr
// S_GRANT | r_owner owns the fifo port until burst end or withdrawal

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BYTE_WIDTH = 1,
  parameter int BURST_LEN  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_wr_en,
  input  logic [NUM_REQ*BYTE_WIDTH*8-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]              req_wr_ack,
  output logic [NUM_REQ-1:0]              req_grant,
  output logic                            fifo_wr_en,
  output logic [BYTE_WIDTH*8-1:0]         fifo_wr_data,
  input  logic                            fifo_wr_full,
  output logic                            busy
);

  localparam int DW = BYTE_WIDTH * 8;
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN) + 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t              r_state;
  logic [IW-1:0]       r_owner;
  logic [IW-1:0]       r_ptr;
  logic [CW-1:0]       r_cnt;
  logic [NUM_REQ-1:0]  r_grant;

  logic                w_found_hi;
  logic [IW-1:0]       w_sel_hi;
  logic                w_found_any;
  logic [IW-1:0]       w_sel_any;
  logic [IW-1:0]       w_sel;
  logic                w_in_grant;
  logic                w_owner_req;
  logic                w_accept;
  logic                w_last_beat;

  // The search is split into two parts. First, look for the lowest set bit
  // above the pointer. If there is none, fall back to the lowest set bit
  // overall. This gives the same result as a rotating priority encoder
  // that starts at pointer+1.
  always_comb begin
    w_found_hi  = 1'b0;
    w_sel_hi    = '0;
    w_found_any = 1'b0;
    w_sel_any   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_wr_en[i]) begin
        w_found_any = 1'b1;
        w_sel_any   = IW'(i);
        if (i > int'(r_ptr)) begin
          w_found_hi = 1'b1;
          w_sel_hi   = IW'(i);
        end
      end
    end
  end

  assign w_sel       = w_found_hi ? w_sel_hi : w_sel_any;
  assign w_in_grant  = (r_state == S_GRANT);
  assign w_owner_req = req_wr_en[r_owner];
  assign w_accept    = w_in_grant & w_owner_req & ~fifo_wr_full;
  assign w_last_beat = (r_cnt == CW'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= IW'(NUM_REQ - 1);
      r_owner <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found_any) begin
            r_owner <= w_sel;
            r_ptr   <= w_sel;
            r_cnt   <= '0;
            r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!w_owner_req) begin
            r_grant <= '0;
            r_state <= S_IDLE;
          end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last_beat) begin
              r_grant <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_grant <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are forced low while rst is asserted. This stops an
  // in-flight burst from acking or writing during the reset cycle itself.
  assign fifo_wr_en   = w_accept & ~rst;
  assign fifo_wr_data = (w_in_grant && !rst) ? req_wr_data[r_owner*DW +: DW] : '0;
  assign req_wr_ack   = (w_accept && !rst) ? r_grant : '0;
  assign req_grant    = rst ? '0 : r_grant;
  assign busy         = w_in_grant & ~rst;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int BW = 1;
  localparam int BL = 4;
  localparam int DW = BW * 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_wr_en = '1;
  logic [NR*DW-1:0]  req_wr_data;
  logic [NR-1:0]     req_wr_ack;
  logic [NR-1:0]     req_grant;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic              fifo_wr_full = 1'b0;
  logic              busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc_no = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;
  int          seq[NR];
  int          eseq[NR];
  logic [NR-1:0] ack_s = '0;

  fifo_wr_arbiter #(.NUM_REQ(NR), .BYTE_WIDTH(BW), .BURST_LEN(BL)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_wr_en    (req_wr_en),
    .req_wr_data  (req_wr_data),
    .req_wr_ack   (req_wr_ack),
    .req_grant    (req_grant),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_full (fifo_wr_full),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Requester model: each requester i offers the byte {i, seq[i]}.
  // It moves to its next byte only after that beat has been acked.
  always_comb begin
    req_wr_data = '0;
    for (int i = 0; i < NR; i++)
      req_wr_data[i*DW +: DW] = 8'(i * 64 + seq[i]);
  end

  always @(negedge clk) ack_s = req_wr_ack;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++)
      if (ack_s[i]) seq[i] = seq[i] + 1;
    ack_s = '0;
  end

  // Scoreboard monitor: every fifo write must match the next expected beat.
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat_data: got %02h with no beat expected", fifo_wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fifo_wr_data !== mon_exp) begin
          n_err++;
          $display("FAIL beat_data: got %02h want %02h", fifo_wr_data, mon_exp);
        end
      end
    end
  end

  // One cycle: drive the inputs, queue the expected beat, then check the
  // outputs on the falling edge.
  task automatic cyc(input logic r, input logic [NR-1:0] rq, input logic f,
                     input logic [NR-1:0] eg, input logic ew);
    logic [NR-1:0] eack;
    int own;
    rst          = r;
    req_wr_en    = rq;
    fifo_wr_full = f;
    eack = ew ? eg : '0;
    if (ew) begin
      own = 0;
      for (int i = 0; i < NR; i++) if (eg[i]) own = i;
      exp_q.push_back(8'(own * 64 + eseq[own]));
      eseq[own] = eseq[own] + 1;
    end
    @(negedge clk);
    n_vec++;
    if (req_grant !== eg || req_wr_ack !== eack || fifo_wr_en !== ew ||
        busy !== (|eg) || (eg == '0 && fifo_wr_data !== '0)) begin
      n_err++;
      $display("FAIL cycle_%0d: grant=%b ack=%b wr_en=%b busy=%b data=%02h want grant=%b ack=%b wr_en=%b busy=%b",
               cyc_no, req_grant, req_wr_ack, fifo_wr_en, busy, fifo_wr_data,
               eg, eack, ew, |eg);
    end
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      seq[i]  = 0;
      eseq[i] = 0;
    end
    @(posedge clk);
    #1;

    // Reset held for 3 cycles while everyone requests: all outputs are 0.
    repeat (3) cyc(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);

    // Release: one IDLE cycle, then round robin 0,1,2,3,0 with 4-beat bursts.
    cyc(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      if ((k - 1) % 5 < 4)
        cyc(1'b0, 4'b1111, 1'b0, 4'(1 << (((k - 1) / 5) % 4)), 1'b1);
      else
        cyc(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0);
    end

    // Back-pressure on requester 1: 2 beats, 3 stalled cycles, 2 more beats.
    repeat (2) cyc(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1);
    repeat (3) cyc(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0);
    repeat (2) cyc(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1);
    cyc(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0);

    // Early release: requester 2 withdraws after 2 beats, then 3 is granted.
    repeat (2) cyc(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1);
    cyc(1'b0, 4'b1011, 1'b0, 4'b0100, 1'b0);
    cyc(1'b0, 4'b1011, 1'b0, 4'b0000, 1'b0);
    repeat (3) cyc(1'b0, 4'b1011, 1'b0, 4'b1000, 1'b1);

    // Single requester 3: it finishes its burst, then gets 4-beat re-grants,
    // each preceded by one IDLE cycle. This exercises the pointer wrap.
    cyc(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1);
    cyc(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0);
    repeat (4) cyc(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1);
    cyc(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0);
    repeat (4) cyc(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1);
    cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Reset mid-burst after beat 1 of requester 0. The search then restarts
    // at requester 0, even though requester 1 is also requesting.
    cyc(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1);
    cyc(1'b1, 4'b0011, 1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1);
    cyc(1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // Every expected beat must have reached the fifo.
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL beats_drained: %0d beats still pending, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
